// File: rtl/wb_arb_pkg.sv
// Shared definitions for the three-master Wishbone round-robin arbiter:
// FSM state encoding, master count, grant type and a grant-to-index helper.
package wb_arb_pkg;

  localparam int NUM_MASTERS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [NUM_MASTERS-1:0] grant_t;

  typedef logic [1:0] master_idx_t;

  // Converts a one-hot grant into the index of the granted master.
  function automatic master_idx_t onehot_to_idx(input grant_t g);
    master_idx_t idx;
    case (g)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the one-hot grant for the first requesting
// master found after last_grant in the cyclic order 0 -> 1 -> 2 -> 0.
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] request,
  input  master_idx_t            last_grant,
  output grant_t                 next_grant
);

  // Search starts at the master just after the previous owner.
  always_comb begin
    next_grant = '0;
    case (last_grant)
      2'd0: begin
        if (request[1])      next_grant = 3'b010;
        else if (request[2]) next_grant = 3'b100;
        else if (request[0]) next_grant = 3'b001;
      end
      2'd1: begin
        if (request[2])      next_grant = 3'b100;
        else if (request[0]) next_grant = 3'b001;
        else if (request[1]) next_grant = 3'b010;
      end
      default: begin
        if (request[0])      next_grant = 3'b001;
        else if (request[1]) next_grant = 3'b010;
        else if (request[2]) next_grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Three-master Wishbone round-robin arbiter (0 = lm32 instr, 1 = lm32 data,
// 2 = DMA) in front of a single conbus master port. A grant is held for the
// whole cycle (cyc high) so bursts and locked sequences are never split.
// Optional bus-error timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  input  logic [3:0]  m2_sel_i,
  input  logic        m2_we_i,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [2:0]  grant_o
);

  arb_state_t             state;
  master_idx_t            last_grant;
  grant_t                 next_grant;
  logic [NUM_MASTERS-1:0] cyc_vec;
  logic                   granted_cyc;
  logic                   busy;
  logic                   err_pulse;

  assign cyc_vec     = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign granted_cyc = |(grant_o & cyc_vec);
  assign busy        = (state == BUSY);

  rr_pick u_rr_pick (
    .request    (cyc_vec),
    .last_grant (last_grant),
    .next_grant (next_grant)
  );

  // Arbitration FSM: grant on the IDLE edge, release when the owner drops cyc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_o    <= '0;
      last_grant <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|cyc_vec) begin
            grant_o <= next_grant;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!granted_cyc) begin
            grant_o    <= '0;
            last_grant <= onehot_to_idx(grant_o);
            state      <= IDLE;
          end
        end
        default: begin
          grant_o <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Forward the owner's request to the slave side; quiet bus when idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (busy) begin
      case (grant_o)
        3'b001: begin
          s_adr_o = m0_adr_i;
          s_dat_o = m0_dat_i;
          s_sel_o = m0_sel_i;
          s_we_o  = m0_we_i;
          s_cyc_o = m0_cyc_i;
          s_stb_o = m0_stb_i;
        end
        3'b010: begin
          s_adr_o = m1_adr_i;
          s_dat_o = m1_dat_i;
          s_sel_o = m1_sel_i;
          s_we_o  = m1_we_i;
          s_cyc_o = m1_cyc_i;
          s_stb_o = m1_stb_i;
        end
        3'b100: begin
          s_adr_o = m2_adr_i;
          s_dat_o = m2_dat_i;
          s_sel_o = m2_sel_i;
          s_we_o  = m2_we_i;
          s_cyc_o = m2_cyc_i;
          s_stb_o = m2_stb_i;
        end
        default: begin
        end
      endcase
    end
  end

  // Read data is broadcast; only the owner ever sees ack or err.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

  assign m0_ack_o = busy && grant_o[0] && s_ack_i;
  assign m1_ack_o = busy && grant_o[1] && s_ack_i;
  assign m2_ack_o = busy && grant_o[2] && s_ack_i;

  assign m0_err_o = err_pulse && grant_o[0];
  assign m1_err_o = err_pulse && grant_o[1];
  assign m2_err_o = err_pulse && grant_o[2];

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;

  // Error fires in the strobe cycle where the wait count hits its limit.
  assign err_pulse = busy && s_stb_o && !s_ack_i && (tmo_cnt == TMO_LAST);

  // Counts consecutive unanswered strobe cycles of the current owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (!busy || s_ack_i || err_pulse) begin
      tmo_cnt <= '0;
    end else if (s_stb_o) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  // Without the timeout the arbiter waits for ack forever; the parameter
  // remains so both builds share one instantiation footprint.
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

  assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios followed by a
// randomized phase, all outputs compared against a transaction-level model.
// Timeout expectations follow WB_ARB_TIMEOUT_EN when it is defined.
module tb_wb_rr_arbiter;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic [31:0] m_adr [3];
  logic [31:0] m_dat [3];
  logic [3:0]  m_sel [3];
  logic [2:0]  m_we;
  logic [2:0]  m_cyc;
  logic [2:0]  m_stb;
  logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
  logic        m0_ack_o, m1_ack_o, m2_ack_o;
  logic        m0_err_o, m1_err_o, m2_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [2:0]  grant_o;

  int checks;
  int failures;
  int owner;
  int last;
  int strobes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_dat[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m2_dat_o(m2_dat_o), .m2_ack_o(m2_ack_o), .m2_err_o(m2_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  // Hard time limit so a stuck run still ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout required=finish checks=%0d", checks);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    last    = 2;
    strobes = 0;
  endtask

  function automatic logic [2:0] owner_mask();
    if (owner < 0) return 3'b000;
    return 3'(1 << owner);
  endfunction

  function automatic logic timeout_due();
    logic due;
    due = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    if (owner >= 0)
      due = m_stb[2'(owner)] && !s_ack_i && (strobes == TMO - 1);
`endif
    return due;
  endfunction

  task automatic checkOutput();
    logic [1:0] oi;
    logic [2:0] eg;
    eg = owner_mask();
    cmp("grant", {29'd0, grant_o}, {29'd0, eg});
    cmp("ack", {29'd0, m2_ack_o, m1_ack_o, m0_ack_o}, {29'd0, (s_ack_i ? eg : 3'b000)});
    cmp("err", {29'd0, m2_err_o, m1_err_o, m0_err_o}, {29'd0, (timeout_due() ? eg : 3'b000)});
    if (owner < 0) begin
      cmp("idle_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      cmp("idle_s_stb", {31'd0, s_stb_o}, 32'd0);
      cmp("idle_s_we", {31'd0, s_we_o}, 32'd0);
    end else begin
      oi = 2'(owner);
      cmp("s_cyc", {31'd0, s_cyc_o}, {31'd0, m_cyc[oi]});
      cmp("s_stb", {31'd0, s_stb_o}, {31'd0, m_stb[oi]});
      cmp("s_we", {31'd0, s_we_o}, {31'd0, m_we[oi]});
      cmp("s_adr", s_adr_o, m_adr[oi]);
      cmp("s_dat", s_dat_o, m_dat[oi]);
      cmp("s_sel", {28'd0, s_sel_o}, {28'd0, m_sel[oi]});
      cmp("m0_dat", m0_dat_o, s_dat_i);
      cmp("m1_dat", m1_dat_o, s_dat_i);
      cmp("m2_dat", m2_dat_o, s_dat_i);
    end
  endtask

  // Advances the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    logic due;
    int   c;
    due = timeout_due();
    if (owner < 0 || s_ack_i || due) strobes = 0;
    else if (m_stb[2'(owner)]) strobes++;
    if (owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        c = (last + k) % 3;
        if (owner < 0 && m_cyc[2'(c)]) owner = c;
      end
    end else if (!m_cyc[2'(owner)]) begin
      last  = owner;
      owner = -1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] stb, input logic ack);
    m_cyc   = cyc;
    m_stb   = stb;
    s_ack_i = ack;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] order [4];
    logic [2:0] g;
    int         w;
    int         first_err;
    int         err_pulses;

    checks   = 0;
    failures = 0;
    m_cyc    = '0;
    m_stb    = '0;
    m_we     = 3'b010;
    s_ack_i  = 1'b0;
    s_dat_i  = 32'hDA7A_0000;
    for (int m = 0; m < 3; m++) begin
      m_adr[m] = 32'h1000_0000 * (m + 1) + 32'h40;
      m_dat[m] = 32'hA000_0000 + 32'(m);
      m_sel[m] = 4'(4'hF >> m);
    end

    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("reset_grant", {29'd0, grant_o}, 32'd0);
    cmp("reset_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    reset = 1'b0;
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] reset priority");
    applyStimulus(3'b011, 3'b011, 1'b0);
    cmp("reset_priority_grant", {29'd0, grant_o}, 32'd1);
    cmp("reset_priority_adr", s_adr_o, m_adr[0]);
    applyStimulus(3'b011, 3'b011, 1'b0);
    applyStimulus(3'b011, 3'b011, 1'b1);
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] round robin");
    do_reset();
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (grant_o === 3'b000 && w < 10) begin
        applyStimulus(3'b111, 3'b111, 1'b0);
        w++;
      end
      cmp("rr_wait_bound", {31'd0, (w < 10)}, 32'd1);
      order[n] = grant_o;
      g = grant_o;
      applyStimulus(3'b111, 3'b111, 1'b1);
      applyStimulus(3'b111 & ~g, 3'b111 & ~g, 1'b0);
    end
    cmp("rr_order0", {29'd0, order[0]}, 32'd1);
    cmp("rr_order1", {29'd0, order[1]}, 32'd2);
    cmp("rr_order2", {29'd0, order[2]}, 32'd4);
    cmp("rr_order3", {29'd0, order[3]}, 32'd1);

    $display("[TB] burst hold");
    applyStimulus(3'b010, 3'b010, 1'b0);
    cmp("burst_m1_grant", {29'd0, grant_o}, 32'd2);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(3'b011, 3'b011, 1'b1);
      cmp("burst_hold_grant", {29'd0, grant_o}, 32'd2);
      cmp("burst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    end
    applyStimulus(3'b001, 3'b001, 1'b0);
    cmp("burst_release_idle", {29'd0, grant_o}, 32'd0);
    applyStimulus(3'b001, 3'b001, 1'b0);
    cmp("burst_m0_grant", {29'd0, grant_o}, 32'd1);
    applyStimulus(3'b001, 3'b001, 1'b1);
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] timeout");
    applyStimulus(3'b100, 3'b100, 1'b0);
    cmp("timeout_m2_grant", {29'd0, grant_o}, 32'd4);
    first_err  = 0;
    err_pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkOutput();
      if (m2_err_o === 1'b1) begin
        err_pulses++;
        if (first_err == 0) first_err = i;
      end
      @(posedge clk);
      model_step();
      #1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    cmp("timeout_first_err_cycle", 32'(first_err), 32'd8);
    cmp("timeout_err_pulses", 32'(err_pulses), 32'd1);
`else
    cmp("no_timeout_err", 32'(err_pulses), 32'd0);
`endif
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(3'b001, 3'b001, 1'b0);
    applyStimulus(3'b001, 3'b001, 1'b1);
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b010, 3'b010, 1'b0);
    applyStimulus(3'b111, 3'b111, 1'b0);
    cmp("pre_reset_busy_cyc", {31'd0, s_cyc_o}, 32'd1);
    reset = 1'b1;
    #1;
    cmp("midreset_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    cmp("midreset_grant", {29'd0, grant_o}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(3'b111, 3'b111, 1'b0);
    cmp("post_reset_grant", {29'd0, grant_o}, 32'd1);
    applyStimulus(3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 3; m++) begin
        if (m_cyc[2'(m)]) begin
          if ($urandom_range(0, 5) == 0) m_cyc[2'(m)] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc[2'(m)] = 1'b1;
        end
        m_stb[2'(m)] = m_cyc[2'(m)] & 1'($urandom_range(0, 1));
        m_we[2'(m)]  = 1'($urandom);
        m_adr[2'(m)] = $urandom;
        m_dat[2'(m)] = $urandom;
        m_sel[2'(m)] = 4'($urandom);
      end
      s_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
